instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the single-cycle RISC-V core, directly upstream of the main control decoder. It owns the program counter, issues word reads to instruction memory over a request/response handshake, and holds each returned instruction stable while the decoder and datapath consume it. It drives the 7-bit opcode field straight into the decoder and accepts branch redirects from the execute logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `Stall`  in  1  consumer not ready; holds the current instruction.
- `BranchTaken`  in  1  redirect request for the held instruction.
- `BranchTarget`  in  32  redirect address.
- `IMemReq`  out  1  read request to instruction memory.
- `IMemAddr`  out  32  read address, always equals PC.
- `IMemReady`  in  1  memory accepts the request this cycle.
- `IMemRValid`  in  1  read data valid.
- `IMemRData`  in  32  read data.
- `Instr`  out  32  held instruction word.
- `Opcode`  out  7  `Instr[6:0]`, feeds the control decoder.
- `InstrPC`  out  32  address of `Instr`.
- `InstrValid`  out  1  `Instr` is valid and held.
- `MisalignFault`  out  1  one-cycle pulse when a redirect target had non-zero bits [1:0].
- `RetireCount`  out  32  number of instructions consumed since reset.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only on reset. Moves to REQ unconditionally on the first clock edge after `rst_n` deasserts.
- REQ: `IMemReq`=1, `IMemAddr`=PC. If `IMemReady`=1 at the edge, moves to WAIT; otherwise stays in REQ with the address held stable.
- WAIT: `IMemReq`=0. If `IMemRValid`=1 at the edge, it latches `Instr`<=`IMemRData` and `InstrPC`<=PC, then moves to HOLD.
- HOLD: `InstrValid`=1. `Instr`, `InstrPC` and `Opcode` are held stable.
  - If `Stall`=1, it stays in HOLD and ignores `BranchTaken`.
  - If `Stall`=0, the instruction is consumed at the edge. `RetireCount` increments and the FSM moves to REQ.
  - On consumption the PC is updated. It becomes {`BranchTarget`[31:2],2'b00} if `BranchTaken`=1, otherwise PC+4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000. `RetireCount` also wraps at 2^32.
- `MisalignFault` is registered. It is high for exactly the cycle after a consuming edge with `BranchTaken`=1 and `BranchTarget`[1:0]≠0; the masked target is still used.
- `IMemRValid` outside WAIT is ignored. `IMemReady` outside REQ is ignored.
- `BranchTaken` outside HOLD, or with `Stall`=1, has no effect.

## Timing
- Reset values (asynchronous on `rst_n`=0): state=IDLE, PC=`RESET_PC`, `Instr`=0, `InstrPC`=0, `InstrValid`=0, `IMemReq`=0, `MisalignFault`=0, `RetireCount`=0. `Opcode`=0 follows from `Instr`.
- Reset mid-operation aborts any outstanding request. A late `IMemRValid` arriving after reset is ignored because the FSM is not in WAIT.
- Zero-wait memory (`IMemReady`=1, `IMemRValid` one cycle later):
  - REQ in cycle n, WAIT in n+1, `InstrValid` in n+2.
  - Next REQ in n+3. Throughput is 1 instruction per 3 cycles.
- Each memory wait state adds one cycle in REQ or WAIT.
- `IMemAddr` equals PC in every state. Only `IMemReq` qualifies it.
- `InstrValid`, `Instr` and `Opcode` are all registered. There is no combinational path from memory inputs to outputs.

## Test plan
- Reset release with `RESET_PC`=0 and zero-wait memory returning 32'h0000_0033 -> `IMemReq` first high the cycle after release with `IMemAddr`=0. Two cycles later `InstrValid`=1, `Opcode`=7'b0110011, `InstrPC`=0. With `Stall`=0, the next request is at address 4 and `RetireCount`=1.
- Backpressure: `IMemReady` low for 3 cycles, `IMemRValid` delayed 2 cycles, `Stall` high 4 cycles in HOLD -> address stable throughout REQ, `Instr` unchanged across the stall, exactly one count increment.
- Branch: held instruction at PC 32'h10, `BranchTaken`=1, `BranchTarget`=32'h40, `Stall`=0 -> next `IMemAddr`=32'h40 and `MisalignFault` stays 0. A target of 32'h42 instead gives address 32'h40 with `MisalignFault`=1 for one cycle.
- `BranchTaken`=1 while `Stall`=1, then `BranchTaken`=0 when `Stall` drops -> PC advances by 4. Spurious `IMemRValid` pulses during REQ and HOLD -> `Instr` unchanged.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC, consume one instruction -> next `IMemAddr`=32'h0000_0000.
- Assert `rst_n`=0 during WAIT, then release and return the stale response -> outputs at reset values immediately, stale data not latched, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction
// over a req/ready + rvalid handshake, and holds it for the decoder until
// the consumer drops Stall.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic        IMemRValid,
   input  logic [31:0] IMemRData,
   output logic [31:0] Instr,
   output logic [6:0]  Opcode,
   output logic [31:0] InstrPC,
   output logic        InstrValid,
   output logic        MisalignFault,
   output logic [31:0] RetireCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic        latch;
   logic        consume;

   // State register; reset aborts any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake decode; outputs depend only on the state register.
   always_comb begin
      state_nxt  = state;
      latch      = 1'b0;
      consume    = 1'b0;
      IMemReq    = 1'b0;
      InstrValid = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            IMemReq = 1'b1;
            if (IMemReady) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (IMemRValid) begin
               latch     = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            InstrValid = 1'b1;
            if (!Stall) begin
               consume   = 1'b1;
               state_nxt = REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Redirect target is forced to a word boundary; sequential flow wraps modulo 2^32.
   always_comb begin
      pc_nxt = pc + 32'd4;
      if (BranchTaken) begin
         pc_nxt = {BranchTarget[31:2], 2'b00};
      end
   end

   // PC, held instruction, retire counter and misalignment pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         Instr         <= '0;
         InstrPC       <= '0;
         RetireCount   <= '0;
         MisalignFault <= 1'b0;
      end else begin
         MisalignFault <= consume & BranchTaken & (|BranchTarget[1:0]);
         if (latch) begin
            Instr   <= IMemRData;
            InstrPC <= pc;
         end
         if (consume) begin
            pc          <= pc_nxt;
            RetireCount <= RetireCount + 32'd1;
         end
      end
   end

   assign IMemAddr = pc;
   assign Opcode   = Instr[6:0];

endmodule
